// File: rtl/fifo_drain_tx.sv
// Drains an 8-deep byte FIFO and sends each byte as an async serial frame
// (start, 8 data bits LSB first, [even parity], stop). Parity: FIFO_DRAIN_TX_PARITY_EN.
module fifo_drain_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tx_enable,
    input  logic             fifo_empty,
    input  logic [7:0]       fifo_dataout,
    output logic             fifo_r_en,
    output logic             tx,
    output logic             busy,
    output logic [CNT_W-1:0] sent_count,
    output logic [2:0]       dbg_state
);

`ifdef FIFO_DRAIN_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        LOAD   = 3'd2,
        START  = 3'd3,
        DATA   = 3'd4,
        PARITY = 3'd5,
        STOP   = 3'd6
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        LOAD   = 3'd2,
        START  = 3'd3,
        DATA   = 3'd4,
        STOP   = 3'd6
    } state_t;
`endif

    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

    state_t           state, state_next;
    logic [15:0]      baud, baud_next;
    logic [2:0]       bit_idx, bit_idx_next;
    logic [7:0]       shift, shift_next;
    logic [CNT_W-1:0] count_next;
    logic             tx_next;
    logic             baud_done;
`ifdef FIFO_DRAIN_TX_PARITY_EN
    logic             par, par_next;
`endif

    assign baud_done = (baud == BAUD_LAST);
    assign fifo_r_en = (state == FETCH);
    assign busy      = (state != IDLE);
    assign dbg_state = state;

    always_comb begin
        state_next   = state;
        baud_next    = baud;
        bit_idx_next = bit_idx;
        shift_next   = shift;
        count_next   = sent_count;
`ifdef FIFO_DRAIN_TX_PARITY_EN
        par_next     = par;
`endif
        case (state)
            IDLE: begin
                if (tx_enable && !fifo_empty) state_next = FETCH;
            end
            FETCH: state_next = LOAD;
            LOAD: begin
                // fifo_dataout is valid now, one cycle after the pop edge
                shift_next   = fifo_dataout;
                baud_next    = '0;
                bit_idx_next = '0;
`ifdef FIFO_DRAIN_TX_PARITY_EN
                par_next     = ^fifo_dataout;
`endif
                state_next   = START;
            end
            START: begin
                if (baud_done) begin
                    baud_next    = '0;
                    bit_idx_next = '0;
                    state_next   = DATA;
                end else begin
                    baud_next = baud + 16'd1;
                end
            end
            DATA: begin
                if (baud_done) begin
                    baud_next = '0;
                    if (bit_idx == 3'd7) begin
`ifdef FIFO_DRAIN_TX_PARITY_EN
                        state_next = PARITY;
`else
                        state_next = STOP;
`endif
                    end else begin
                        bit_idx_next = bit_idx + 3'd1;
                        shift_next   = {1'b0, shift[7:1]};
                    end
                end else begin
                    baud_next = baud + 16'd1;
                end
            end
`ifdef FIFO_DRAIN_TX_PARITY_EN
            PARITY: begin
                if (baud_done) begin
                    baud_next  = '0;
                    state_next = STOP;
                end else begin
                    baud_next = baud + 16'd1;
                end
            end
`endif
            STOP: begin
                if (baud_done) begin
                    baud_next  = '0;
                    count_next = sent_count + 1'b1;
                    state_next = IDLE;
                end else begin
                    baud_next = baud + 16'd1;
                end
            end
            default: state_next = IDLE;
        endcase

        // tx is decoded from the next state so the registered line changes
        // on the same edge the FSM enters each bit.
        tx_next = 1'b1;
        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shift_next[0];
`ifdef FIFO_DRAIN_TX_PARITY_EN
            PARITY:  tx_next = par_next;
`endif
            default: tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            baud       <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            sent_count <= '0;
            tx         <= 1'b1;
`ifdef FIFO_DRAIN_TX_PARITY_EN
            par        <= 1'b0;
`endif
        end else begin
            state      <= state_next;
            baud       <= baud_next;
            bit_idx    <= bit_idx_next;
            shift      <= shift_next;
            sent_count <= count_next;
            tx         <= tx_next;
`ifdef FIFO_DRAIN_TX_PARITY_EN
            par        <= par_next;
`endif
        end
    end

endmodule

// File: tb/tb_fifo_drain_tx.sv
// Bench for fifo_drain_tx: behavioural FIFO, cycle-level line monitor built
// from the frame format, directed scenarios plus a randomized drain phase.
module tb_fifo_drain_tx;
    localparam int C     = 4;
    localparam int CNT_W = 16;
`ifdef FIFO_DRAIN_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             tx_enable = 1'b0;
    logic             fifo_empty = 1'b1;
    logic [7:0]       fifo_dataout = 8'h00;
    logic             fifo_r_en;
    logic             tx;
    logic             busy;
    logic [CNT_W-1:0] sent_count;
    logic [2:0]       dbg_state;

    always #5 clk = ~clk;

    fifo_drain_tx #(.CLKS_PER_BIT(C), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .tx_enable(tx_enable), .fifo_empty(fifo_empty),
        .fifo_dataout(fifo_dataout), .fifo_r_en(fifo_r_en), .tx(tx), .busy(busy),
        .sent_count(sent_count), .dbg_state(dbg_state)
    );

    // Behavioural FIFO: registered read data after the pop edge
    logic [7:0] fifo_q[$];
    logic       push_valid = 1'b0;
    logic [7:0] push_data = 8'h00;
    int         underflows = 0;

    always @(posedge clk) begin
        if (push_valid) fifo_q.push_back(push_data);
        if (fifo_r_en) begin
            if (fifo_q.size() == 0) underflows <= underflows + 1;
            else fifo_dataout <= fifo_q.pop_front();
        end
        fifo_empty <= (fifo_q.size() == 0);
    end

    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    bit          fr_active = 1'b0;
    int          fr_start = 0;
    int          fr_end = 0;
    logic [7:0]  fr_byte = 8'h00;
    logic [15:0] model_count = 16'd0;
    int          frames_done = 0;
    int          rpulses = 0;
    logic [7:0]  exp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic frame_bit(input logic [7:0] b, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return b[idx-1];
`ifdef FIFO_DRAIN_TX_PARITY_EN
        if (idx == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    // One cycle: advance to the negedge, then check the line against the model
    task automatic tick();
        logic exp_tx;
        logic exp_busy;
        @(negedge clk);
        cyc++;
        if (!reset) begin
            fr_active   = 1'b0;
            model_count = 16'd0;
            check_eq("rst_tx", 32'(tx), 32'd1);
            check_eq("rst_busy", 32'(busy), 32'd0);
            check_eq("rst_ren", 32'(fifo_r_en), 32'd0);
            check_eq("rst_count", 32'(sent_count), 32'd0);
        end else begin
            if (fr_active && cyc == fr_end) begin
                fr_active   = 1'b0;
                frames_done++;
                model_count = model_count + 16'd1;
                check_eq("sent_count", 32'(sent_count), 32'(model_count));
            end
            if (fifo_r_en) begin
                rpulses++;
                check_eq("ren_while_busy", 32'(fr_active), 32'd0);
                check_eq("ren_exp_avail", 32'(exp_q.size() > 0), 32'd1);
                if (!fr_active) begin
                    fr_active = 1'b1;
                    fr_start  = cyc + 2;
                    fr_end    = cyc + 2 + NB * C;
                    fr_byte   = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
                end
            end
            exp_tx   = 1'b1;
            exp_busy = 1'b0;
            if (fr_active) begin
                exp_busy = 1'b1;
                if (cyc >= fr_start) exp_tx = frame_bit(fr_byte, (cyc - fr_start) / C);
            end
            check_eq("tx", 32'(tx), 32'(exp_tx));
            check_eq("busy", 32'(busy), 32'(exp_busy));
        end
    endtask

    task automatic push_byte(input logic [7:0] b);
        push_valid = 1'b1;
        push_data  = b;
        exp_q.push_back(b);
        tick();
        push_valid = 1'b0;
    endtask

    task automatic wait_ren(output int gap, input int limit);
        bit seen = 1'b0;
        gap = 0;
        while (!seen && gap < limit) begin
            tick();
            gap++;
            if (fifo_r_en && reset) seen = 1'b1;
        end
        check_eq("wait_ren_timeout", 32'(seen), 32'd1);
    endtask

    task automatic wait_frames(input int target, input int limit);
        int n = 0;
        while (frames_done < target && n < limit) begin
            tick();
            n++;
        end
        check_eq("frames_timeout", 32'(frames_done), 32'(target));
    endtask

    initial begin
        int g;
        int p;
        int base;

        // Asynchronous reset before any clock edge
        #1 reset = 1'b0;
        #1;
        check_eq("async_rst_tx", 32'(tx), 32'd1);
        check_eq("async_rst_ren", 32'(fifo_r_en), 32'd0);
        check_eq("async_rst_busy", 32'(busy), 32'd0);
        check_eq("async_rst_count", 32'(sent_count), 32'd0);
        for (int i = 0; i < 8; i++) begin
            tx_enable = 1'($urandom_range(0, 1));
            tick();
        end
        reset     = 1'b1;
        tx_enable = 1'b1;

        // Empty FIFO: never pop
        repeat (100) tick();
        check_eq("empty_no_ren", 32'(rpulses), 32'd0);

        // Single byte
        push_byte(8'hA5);
        wait_ren(g, 50);
        wait_frames(1, 200);
        repeat (3) tick();
        check_eq("single_count", 32'(sent_count), 32'd1);
        check_eq("single_pulses", 32'(rpulses), 32'd1);
        check_eq("single_fifo_empty", 32'(fifo_q.size()), 32'd0);

        // Back-to-back frames
        tx_enable = 1'b0;
        push_byte(8'h00);
        push_byte(8'hFF);
        push_byte(8'h3C);
        tick();
        tx_enable = 1'b1;
        wait_ren(g, 50);
        wait_ren(g, 200);
        check_eq("b2b_gap1", 32'(g), 32'(3 + NB * C));
        wait_ren(g, 200);
        check_eq("b2b_gap2", 32'(g), 32'(3 + NB * C));
        wait_frames(4, 200);
        check_eq("b2b_count", 32'(sent_count), 32'd4);

        // Enable gating mid-frame
        tx_enable = 1'b0;
        push_byte(8'h55);
        push_byte(8'h66);
        tick();
        tx_enable = 1'b1;
        wait_ren(g, 50);
        repeat (2 + C + 5) tick();
        tx_enable = 1'b0;
        p = rpulses;
        wait_frames(5, 200);
        repeat (60) tick();
        check_eq("gate_no_pop", 32'(rpulses), 32'(p));
        check_eq("gate_fifo_left", 32'(fifo_q.size()), 32'd1);
        tx_enable = 1'b1;
        wait_frames(6, 300);
        check_eq("gate_fifo_empty", 32'(fifo_q.size()), 32'd0);

        // Reset during DATA bit 3 (byte has bit 3 = 0, so tx is low then)
        tx_enable = 1'b0;
        push_byte(8'h35);
        push_byte(8'hC3);
        tick();
        tx_enable = 1'b1;
        wait_ren(g, 50);
        repeat (2 + 4 * C) tick();
        check_eq("pre_rst_tx", 32'(tx), 32'd0);
        #2 reset = 1'b0;
        #1;
        check_eq("mid_rst_tx", 32'(tx), 32'd1);
        check_eq("mid_rst_busy", 32'(busy), 32'd0);
        check_eq("mid_rst_count", 32'(sent_count), 32'd0);
        repeat (3) tick();
        reset = 1'b1;
        tick();
        check_eq("post_rst_count", 32'(sent_count), 32'd0);
        base = frames_done;
        wait_frames(base + 1, 300);
        check_eq("resume_count", 32'(sent_count), 32'd1);

        // Randomized pushes with random enable gating
        base = frames_done;
        for (int i = 0; i < 12; i++) begin
            push_byte(8'($urandom_range(0, 255)));
            repeat ($urandom_range(0, 30)) begin
                tx_enable = ($urandom_range(0, 3) != 0);
                tick();
            end
        end
        tx_enable = 1'b1;
        wait_frames(base + 12, 20000);
        repeat (5) tick();

        check_eq("final_underflows", 32'(underflows), 32'd0);
        check_eq("final_fifo_empty", 32'(fifo_q.size()), 32'd0);
        check_eq("final_exp_empty", 32'(exp_q.size()), 32'd0);
        check_eq("final_count", 32'(sent_count), 32'(model_count));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
